// File: rtl/pipe_pkg.sv
// Shared definitions for the RISC-V pipeline register slice: the canonical NOP,
// the datapath width and the hazard-unit control bundle.
package pipe_pkg;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Driven by the hazard unit and fanned out to every pipeline boundary.
    typedef struct packed {
        logic stall;
        logic flush;
    } pipe_ctrl_t;

endpackage : pipe_pkg

// File: rtl/pipe_stage_cell.sv
// One pipeline slot: WIDTH-bit payload plus valid, with async reset,
// hold enable and a synchronous clear that wins over the enable.
module pipe_stage_cell #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_d;

    // A clear discards the incoming payload even when the slot is held.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clr_i) begin
            data_d  = RESET_VAL;
            valid_d = 1'b0;
        end else if (en_i) begin
            data_d  = data_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= RESET_VAL;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule : pipe_stage_cell

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage pipeline register with stall, flush and live occupancy count.
// Optional perf counters (stall_cycles, flush_count) when PIPE_STAGE_REG_PERF_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    input  logic                         stall,
    input  logic                         flush,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_REG_PERF_EN
    ,
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  flush_count
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    pipe_ctrl_t       ctrl;
    logic [WIDTH-1:0] stg_data  [DEPTH];
    logic [DEPTH-1:0] stg_valid;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    assign ctrl.stall = stall;
    assign ctrl.flush = flush;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + OCC_W'(v[i]);
        end
        return n;
    endfunction

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage_cell #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .en_i   (~ctrl.stall),
                .clr_i  (ctrl.flush),
                .data_i (in_data),
                .valid_i(in_valid),
                .data_o (stg_data[k]),
                .valid_o(stg_valid[k])
            );
        end else begin : g_body
            pipe_stage_cell #(
                .WIDTH    (WIDTH),
                .RESET_VAL(RESET_VAL)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .en_i   (~ctrl.stall),
                .clr_i  (ctrl.flush),
                .data_i (stg_data[k-1]),
                .valid_i(stg_valid[k-1]),
                .data_o (stg_data[k]),
                .valid_o(stg_valid[k])
            );
        end
    end

    // Modular arithmetic is safe: a full pipe always retires its tail on a shift.
    always_comb begin
        occ_d = occ_q;
        if (ctrl.flush) begin
            occ_d = '0;
        end else if (!ctrl.stall) begin
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(stg_valid[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign out_data  = stg_data[DEPTH-1];
    assign out_valid = stg_valid[DEPTH-1];
    assign occupancy = occ_q;

`ifdef PIPE_STAGE_REG_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    // Only stalls that actually freeze live work are counted.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (ctrl.stall && !ctrl.flush && (occ_q != '0)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (ctrl.flush) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

    a_occ_matches_valids : assert property (@(posedge clk) disable iff (rst)
        (occ_q == popcount(stg_valid)) && (occ_q <= OCC_W'(DEPTH)));

endmodule : pipe_stage_reg
